// File: rtl/spi_pkg.sv
// Shared definitions for the image-link SPI sender and receiver.
// Holds the sender state encoding, the SPI mode and the default frame size.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } sender_state_t;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;
    localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

    localparam int IMG_BYTES_DEFAULT = 98;

    // Bits needed to hold a down-count from (n-1) to 0.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period generator: toggles sclk_level every CLK_DIV cycles while enabled.
// When disabled the level is forced low and the divider reloads, so each enable starts a full low phase.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase_tick,
    output logic sclk_level
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign phase_tick = en && (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            sclk_level <= 1'b0;
        end else if (!en) begin
            div_cnt    <= DIV_LAST;
            sclk_level <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt    <= DIV_LAST;
            sclk_level <= ~sclk_level;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_image_sender.sv
// SPI mode-0 initiator that streams one image frame from a synchronous-read buffer per accepted start.
// FSM, shift register and byte index live here; SCLK timing comes from spi_clk_gen.
module spi_image_sender
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int IMG_BYTES = IMG_BYTES_DEFAULT,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int ADDR_W    = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              send_image,
    output logic              byte_rd_en,
    output logic [ADDR_W-1:0] byte_addr,
    input  logic [7:0]        byte_rd_data,
    output logic              SCLK,
    output logic              COPI,
    output logic              spi_cs_n,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(IMG_BYTES - 1);

    sender_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [6:0]        shreg_q, shreg_d;
    logic [2:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              copi_q, copi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;

    logic phase_tick;
    logic sclk_level;

    // Abort gates the divider in the same cycle so SCLK is already low when the FSM lands in IDLE.
    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         ((state_q == ST_SHIFT) && !abort),
        .phase_tick (phase_tick),
        .sclk_level (sclk_level)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        copi_d  = copi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en_d = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            bit_d   = '0;
            cnt_d   = '0;
            copi_d  = 1'b0;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && send_image && !abort) begin
                        state_d = ST_FETCH;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        rd_en_d = 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    shreg_d = byte_rd_data[6:0];
                    copi_d  = byte_rd_data[7];
                    bit_d   = 3'd7;
                    if (idx_q == '0) begin
                        state_d = ST_SETUP;
                        cs_n_d  = 1'b0;
                        cnt_d   = SETUP_LAST;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // A tick while SCLK is high is a falling edge: present the next bit or finish the byte.
                    if (phase_tick && sclk_level) begin
                        if (bit_q != 3'd0) begin
                            bit_d   = bit_q - 1'b1;
                            copi_d  = shreg_q[6];
                            shreg_d = {shreg_q[5:0], 1'b0};
                        end else if (idx_q == IDX_LAST) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LAST;
                        end else begin
                            state_d = ST_FETCH;
                            idx_d   = idx_q + 1'b1;
                            rd_en_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                        cs_n_d  = 1'b1;
                        copi_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            copi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            copi_q  <= copi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign byte_rd_en = rd_en_q;
    assign byte_addr  = idx_q;
    assign SCLK       = sclk_level;
    assign COPI       = copi_q;
    assign spi_cs_n   = cs_n_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
